// File: rtl/sp_pkg.sv
// Shared definitions for the solar-panel optimizer acquisition path:
// ADC frame geometry, output width and the sampler FSM state encoding.
package sp_pkg;

  // 16-bit AD7476A-class frame: 4 leading zeros followed by 12 data bits.
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_ZEROS = 4;
  localparam int ADC_DATA_MSB   = 11;

  // Width of the averaged panel voltage handed to the optimizer.
  localparam int V_WIDTH        = 10;

  // Sampler FSM state, kept as plain encoded constants for legacy tools.
  typedef logic [1:0] adc_state_t;

  localparam adc_state_t ST_IDLE  = 2'd0;
  localparam adc_state_t ST_CONV  = 2'd1;
  localparam adc_state_t ST_DONE  = 2'd2;
  localparam adc_state_t ST_QUIET = 2'd3;

endpackage

// File: rtl/adc_spi_shift.sv
// Serial front end for the ADC: generates ADC_SCLK from the system clock,
// counts its edges and shifts in one 16-bit frame, MSB first.
// A start pulse launches a frame. The done pulse is raised in the last clock
// of the frame, which is the cycle whose closing edge is the 16th ADC_SCLK
// rising edge. While done is high, frame already carries the bit that this
// edge samples. The caller can therefore register its results on that same
// edge.
module adc_spi_shift
  import sp_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      sdata,
  output logic                      sclk,
  output logic                      done,
  output logic [ADC_FRAME_BITS-1:0] frame
);

  // One frame is 16 falling plus 16 rising edges, starting from idle-high.
  localparam int TOGGLES = 2 * ADC_FRAME_BITS;
  localparam int TOG_W   = $clog2(TOGGLES);
  localparam int DIV_W   = (CLK_DIV < 2) ? 1 : $clog2(CLK_DIV);

  logic                      active;
  logic [DIV_W-1:0]          div_cnt;
  logic [TOG_W-1:0]          tog_cnt;
  logic [ADC_FRAME_BITS-1:0] shift_q;
  logic                      toggle_now;

  assign toggle_now = active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign done       = toggle_now && (tog_cnt == TOG_W'(TOGGLES - 1));
  assign frame      = {shift_q[ADC_FRAME_BITS-2:0], sdata};

  // Divider, edge counter and shift register; SCLK returns high after edge 32.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      active  <= 1'b0;
      div_cnt <= '0;
      tog_cnt <= '0;
      sclk    <= 1'b1;
      shift_q <= '0;
    end else if (start) begin
      active  <= 1'b1;
      div_cnt <= '0;
      tog_cnt <= '0;
    end else if (active) begin
      if (toggle_now) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        tog_cnt <= tog_cnt + 1'b1;
        if (!sclk) begin
          shift_q <= {shift_q[ADC_FRAME_BITS-2:0], sdata};
        end
        if (done) begin
          active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_sampler.sv
// Panel-voltage acquisition stage.
// A free-running sample timer launches ADC frames. Each frame is checked for
// its four leading zeros, and 2^AVG_LOG2 good samples are averaged into V_OUT.
// V_OUT only changes when V_VALID pulses, so the optimizer always sees a
// settled value.
module adc_sampler
  import sp_pkg::*;
#(
  parameter int CLK_DIV       = 2,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int QUIET_CYCLES  = 4,
  parameter int AVG_LOG2      = 2
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               ADC_SDATA,
  output logic               ADC_CS_N,
  output logic               ADC_SCLK,
  output logic [V_WIDTH-1:0] V_OUT,
  output logic               V_VALID,
  output logic               FRAME_ERR,
  output logic               OVERRUN
);

  localparam int TMR_W = (SAMPLE_PERIOD < 3) ? 1 : $clog2(SAMPLE_PERIOD);
  localparam int Q_W   = (QUIET_CYCLES < 2) ? 1 : $clog2(QUIET_CYCLES);
  localparam int ACC_W = V_WIDTH + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;

  adc_state_t                state;
  adc_state_t                state_next;
  logic [TMR_W-1:0]          tmr;
  logic [Q_W-1:0]            q_cnt;
  logic                      tick;
  logic                      start;
  logic                      quiet_last;
  logic                      shift_done;
  logic [ADC_FRAME_BITS-1:0] frame;
  logic                      frame_good;
  logic [V_WIDTH-1:0]        sample;
  logic [ACC_W-1:0]          acc;
  logic [ACC_W-1:0]          sum;
  logic [CNT_W-1:0]          cnt;
  logic [CNT_W-1:0]          cnt_inc;
  logic                      avg_full;
  logic                      unused_frame_lsbs;

  assign tick       = (tmr == TMR_W'(SAMPLE_PERIOD - 1));
  assign start      = (state == ST_IDLE) && tick;
  assign quiet_last = (q_cnt == Q_W'(QUIET_CYCLES - 1));

  // The two LSBs of the 12-bit conversion are dropped when forming a sample.
  assign unused_frame_lsbs = ^frame[ADC_DATA_MSB-V_WIDTH:0];

  adc_spi_shift #(
    .CLK_DIV (CLK_DIV)
  ) u_spi (
    .clk   (CLK),
    .rst   (RESET),
    .start (start),
    .sdata (ADC_SDATA),
    .sclk  (ADC_SCLK),
    .done  (shift_done),
    .frame (frame)
  );

  // Free-running sample timer; wraps at SAMPLE_PERIOD-1 whatever the FSM does.
  always_ff @(posedge CLK) begin
    if (RESET || tick) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 1'b1;
    end
  end

  // Next-state rules: IDLE waits for a tick, CONV for the last SCLK edge.
  // NOTE: state_next gets a default before the case so no path infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (tick)       state_next = ST_CONV;
      ST_CONV:  if (shift_done) state_next = ST_DONE;
      ST_DONE:                  state_next = ST_QUIET;
      ST_QUIET: if (quiet_last) state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // FSM register. ADC_CS_N is registered from the next state so it is glitch-free.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      q_cnt    <= '0;
      ADC_CS_N <= 1'b1;
    end else begin
      state    <= state_next;
      q_cnt    <= (state == ST_QUIET) ? q_cnt + 1'b1 : '0;
      ADC_CS_N <= (state_next != ST_CONV);
    end
  end

  // Sticky overrun: a tick that finds the FSM busy is dropped and flagged.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OVERRUN <= 1'b0;
    end else if (tick && (state != ST_IDLE)) begin
      OVERRUN <= 1'b1;
    end
  end

  // The frame is judged on the edge that ends CONV. Results therefore appear
  // together with the rising ADC_CS_N, and DONE is the cycle that shows them.
  assign frame_good = (frame[ADC_FRAME_BITS-1 -: ADC_LEAD_ZEROS] == '0);
  assign sample     = frame[ADC_DATA_MSB -: V_WIDTH];
  assign sum        = acc + ACC_W'(sample);
  assign cnt_inc    = cnt + 1'b1;
  assign avg_full   = (cnt_inc == CNT_W'(1 << AVG_LOG2));

  // Accumulate good samples; publish the truncated mean once the set is full.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc       <= '0;
      cnt       <= '0;
      V_OUT     <= '0;
      V_VALID   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      V_VALID   <= 1'b0;
      FRAME_ERR <= 1'b0;
      if (shift_done && (state == ST_CONV)) begin
        if (!frame_good) begin
          FRAME_ERR <= 1'b1;
        end else if (avg_full) begin
          V_OUT   <= sum[ACC_W-1:AVG_LOG2];
          V_VALID <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_sampler.sv
// Bench for adc_sampler. Three instances run side by side:
// u0 (default test parameters) is compared every cycle against a timeline
// model; u1 uses a short sample period to provoke overruns; u2 uses
// AVG_LOG2=0 for pass-through.
module tb_adc_sampler;

  localparam int D     = 2;
  localparam int SP    = 100;
  localparam int SP1   = 40;
  localparam int Q     = 4;
  localparam int NAVG  = 4;
  localparam int CONVL = 32 * D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
  logic       sd0 = 1'b0, sd1 = 1'b0, sd2 = 1'b0;
  logic       cs0, cs1, cs2, sclk0, sclk1, sclk2;
  logic [9:0] vout0, vout1, vout2;
  logic       vv0, vv1, vv2, err0, err1, err2, ovr0, ovr1, ovr2;

  adc_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(SP), .QUIET_CYCLES(Q), .AVG_LOG2(2)) u0 (
    .CLK(clk), .RESET(rst0), .ADC_SDATA(sd0), .ADC_CS_N(cs0), .ADC_SCLK(sclk0),
    .V_OUT(vout0), .V_VALID(vv0), .FRAME_ERR(err0), .OVERRUN(ovr0));
  adc_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(SP1), .QUIET_CYCLES(Q), .AVG_LOG2(2)) u1 (
    .CLK(clk), .RESET(rst1), .ADC_SDATA(sd1), .ADC_CS_N(cs1), .ADC_SCLK(sclk1),
    .V_OUT(vout1), .V_VALID(vv1), .FRAME_ERR(err1), .OVERRUN(ovr1));
  adc_sampler #(.CLK_DIV(D), .SAMPLE_PERIOD(SP), .QUIET_CYCLES(Q), .AVG_LOG2(0)) u2 (
    .CLK(clk), .RESET(rst2), .ADC_SDATA(sd2), .ADC_CS_N(cs2), .ADC_SCLK(sclk2),
    .V_OUT(vout2), .V_VALID(vv2), .FRAME_ERR(err2), .OVERRUN(ovr2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- ADC models: drive the next bit on each SCLK fall ----------------
  logic [15:0] adc_q0[$];
  logic [15:0] adc_cur0;
  int          adc_bit0, adc_bit1, adc_bit2;

  always @(negedge cs0) begin
    adc_cur0 = (adc_q0.size() > 0) ? adc_q0.pop_front() : 16'h0000;
    adc_bit0 = 0;
  end
  always @(negedge sclk0) if (!cs0 && adc_bit0 < 16) begin
    sd0 = adc_cur0[15 - adc_bit0];
    adc_bit0++;
  end

  logic [15:0] frame1 = 16'h0FFC;
  always @(negedge cs1) adc_bit1 = 0;
  always @(negedge sclk1) if (!cs1 && adc_bit1 < 16) begin
    sd1 = frame1[15 - adc_bit1];
    adc_bit1++;
  end

  logic [15:0] frame2 = 16'h0ABC;
  always @(negedge cs2) adc_bit2 = 0;
  always @(negedge sclk2) if (!cs2 && adc_bit2 < 16) begin
    sd2 = frame2[15 - adc_bit2];
    adc_bit2++;
  end

  // ---------------- u0 timeline model ----------------
  // Cycle n counts from the first cycle after reset. A tick falls on
  // n % SP == SP-1. A tick that finds the sampler free opens a frame with
  // CS low for CONVL cycles. The DONE cycle follows, and the sampler is free
  // again Q+1 cycles after that.
  logic [15:0] m_q[$];
  logic [15:0] m_cur;
  int  m_n, m_start, m_free, m_acc, m_cnt, exp_vout;
  bit  m_started, m_ready = 1'b0;
  bit  exp_cs, exp_sclk, exp_valid, exp_err, exp_ovr;

  always @(posedge clk) begin
    if (rst0) begin
      m_n = 0; m_started = 0; m_free = 0; m_acc = 0; m_cnt = 0;
      exp_vout = 0; exp_ovr = 0; exp_valid = 0; exp_err = 0;
      exp_cs = 1; exp_sclk = 1; m_ready = 1;
    end else if (m_ready) begin
      exp_valid = 0;
      exp_err   = 0;
      if (m_n % SP == SP - 1) begin
        if (m_n >= m_free) begin
          m_started = 1;
          m_start   = m_n;
          m_free    = m_n + CONVL + Q + 2;
          m_cur     = (m_q.size() > 0) ? m_q.pop_front() : 16'h0000;
        end else begin
          exp_ovr = 1;
        end
      end
      m_n++;
      if (m_started && m_n > m_start && m_n <= m_start + CONVL) begin
        exp_cs   = 0;
        exp_sclk = (((m_n - m_start - 1) / D) % 2) == 0;
      end else begin
        exp_cs   = 1;
        exp_sclk = 1;
      end
      if (m_started && m_n == m_start + CONVL + 1) begin
        if (m_cur[15:12] != 4'h0) begin
          exp_err = 1;
        end else begin
          m_acc += int'(m_cur[11:2]);
          m_cnt++;
          if (m_cnt == NAVG) begin
            exp_vout  = m_acc / NAVG;
            exp_valid = 1;
            m_acc = 0;
            m_cnt = 0;
          end
        end
      end
    end
  end

  // Compare u0 against the model on every cycle, away from the active edge.
  always @(negedge clk) if (m_ready) begin
    check("u0_cs_n",      cs0,   exp_cs);
    check("u0_sclk",      sclk0, exp_sclk);
    check("u0_v_valid",   vv0,   exp_valid);
    check("u0_frame_err", err0,  exp_err);
    check("u0_v_out",     vout0, exp_vout);
    check("u0_overrun",   ovr0,  exp_ovr);
  end

  int vv_cnt0 = 0, err_cnt0 = 0;
  always @(posedge clk) begin
    if (vv0)  vv_cnt0++;
    if (err0) err_cnt0++;
  end

  // ---------------- u1: overrun instance ----------------
  int   run1 = 0, rises1 = 0, frames1 = 0;
  logic pcs1 = 1'b1, psclk1 = 1'b1;
  always @(negedge clk) begin
    if (rst1) begin
      run1 = 0; rises1 = 0; pcs1 = 1'b1; psclk1 = 1'b1;
    end else begin
      if (!psclk1 && sclk1) rises1++;
      if (!cs1) begin
        if (pcs1) begin
          if (frames1 == 0) check("u1_overrun_before_first_frame", ovr1, 0);
          run1 = 0;
          rises1 = 0;
        end
        run1++;
      end else if (!pcs1) begin
        check("u1_cs_low_cycles", run1, CONVL);
        check("u1_sclk_rises", rises1, 16);
        check("u1_overrun_set", ovr1, 1);
        frames1++;
      end
      pcs1   = cs1;
      psclk1 = sclk1;
    end
  end

  // ---------------- u2: pass-through instance ----------------
  bit   seen2 = 1'b0;
  logic pcs2  = 1'b1;
  always @(negedge clk) begin
    if (!rst2 && vv2 && !seen2) begin
      seen2 = 1'b1;
      check("u2_v_out", vout2, 687);
      check("u2_valid_with_cs_rise", {30'd0, pcs2, cs2}, 32'd1);
    end
    pcs2 = cs2;
  end

  // ---------------- directed sequence on u0 ----------------
  task automatic push0(input logic [15:0] f);
    adc_q0.push_back(f);
    m_q.push_back(f);
  endtask

  task automatic wait_frames(input int n, input string tag);
    int   seen = 0;
    logic prev = cs0;
    for (int c = 0; c < n * SP + 200 && seen < n; c++) begin
      @(negedge clk);
      if (!prev && cs0) seen++;
      prev = cs0;
    end
    check({tag, "_frames_completed"}, seen, n);
  endtask

  initial begin
    int k, lo, rises, vb, eb;
    logic ps;

    repeat (3) @(negedge clk);
    check("reset_cs_n",      cs0,   1);
    check("reset_sclk",      sclk0, 1);
    check("reset_v_out",     vout0, 0);
    check("reset_v_valid",   vv0,   0);
    check("reset_frame_err", err0,  0);
    check("reset_overrun",   ovr0,  0);

    // Four full-scale frames: mean of 1023 appears only after the fourth.
    repeat (4) push0(16'h0FFC);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    vb = vv_cnt0;
    k = 0;
    while (cs0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("first_cs_fall_cycle", k, SP);
    lo = 0;
    while (!cs0 && lo < 1000) begin
      @(negedge clk);
      lo++;
    end
    check("cs_low_cycles", lo, CONVL);
    wait_frames(2, "s1_f23");
    @(negedge clk);
    check("s1_no_valid_after_3", vv_cnt0 - vb, 0);
    wait_frames(1, "s1_f4");
    @(negedge clk);
    check("s1_valid_count", vv_cnt0 - vb, 1);
    check("s1_v_out", vout0, 1023);

    // Mixed samples 256, 512, 768, 0: mean 384.
    vb = vv_cnt0;
    push0(16'h0400); push0(16'h0800); push0(16'h0C00); push0(16'h0000);
    wait_frames(4, "s2");
    @(negedge clk);
    check("s2_valid_count", vv_cnt0 - vb, 1);
    check("s2_v_out", vout0, 384);

    // Bad leading bits are rejected; four samples of 1 then give 1.
    vb = vv_cnt0;
    eb = err_cnt0;
    push0(16'h8FFC);
    repeat (4) push0(16'h0004);
    wait_frames(1, "s3_bad");
    @(negedge clk);
    check("s3_err_count", err_cnt0 - eb, 1);
    check("s3_no_valid_on_bad", vv_cnt0 - vb, 0);
    wait_frames(4, "s3_good");
    @(negedge clk);
    check("s3_valid_count", vv_cnt0 - vb, 1);
    check("s3_err_total", err_cnt0 - eb, 1);
    check("s3_v_out", vout0, 1);

    // Reset after the 8th SCLK rise of the third 0x0800 frame.
    repeat (3) push0(16'h0800);
    wait_frames(2, "s4_pre");
    k = 0;
    while (cs0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    rises = 0;
    ps = sclk0;
    for (int c = 0; c < 1000 && rises < 8; c++) begin
      @(negedge clk);
      if (!ps && sclk0) rises++;
      ps = sclk0;
    end
    check("s4_rises_before_reset", rises, 8);
    vb = vv_cnt0;
    eb = err_cnt0;
    rst0 = 1'b1;
    @(negedge clk);
    check("s4_reset_cs_n",    cs0,   1);
    check("s4_reset_sclk",    sclk0, 1);
    check("s4_reset_v_out",   vout0, 0);
    check("s4_reset_overrun", ovr0,  0);
    repeat (4) push0(16'h0800);
    rst0 = 1'b0;
    @(negedge clk);
    check("s4_no_valid_on_reset", vv_cnt0 - vb, 0);
    check("s4_no_err_on_reset",   err_cnt0 - eb, 0);
    wait_frames(4, "s4_post");
    @(negedge clk);
    check("s4_valid_count", vv_cnt0 - vb, 1);
    check("s4_v_out", vout0, 512);

    // Side instances ran concurrently the whole time.
    check("u1_frames_seen", (frames1 >= 3) ? 1 : 0, 1);
    check("u1_overrun_sticky", ovr1, 1);
    check("u2_valid_seen", seen2, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
